// File: rtl/decode_seq_pkg.sv
// decode_seq_pkg: shared definitions for decode_sequencer.
//   - 5-bit opcode values (INSTR[15:11])
//   - phase encoding (also the state register encoding)
//   - mux1_sel / pcmux_sel codes
//   - op_class_t: one-hot op classes produced by decode_seq_opdec
package decode_seq_pkg;

  localparam logic [4:0] OP_STP = 5'h00, OP_ADR = 5'h01, OP_ADI = 5'h02, OP_ADM = 5'h03;
  localparam logic [4:0] OP_SBR = 5'h04, OP_SBI = 5'h05, OP_SBM = 5'h06, OP_MLR = 5'h07;
  localparam logic [4:0] OP_XSL = 5'h08, OP_XSR = 5'h09, OP_BBO = 5'h0A, OP_PSH = 5'h0B;
  localparam logic [4:0] OP_POP = 5'h0C, OP_LDR = 5'h0D, OP_STI = 5'h0E, OP_LDI = 5'h0F;
  localparam logic [4:0] OP_STA = 5'h10, OP_LDA = 5'h11, OP_JMR = 5'h12, OP_JMP = 5'h13;
  localparam logic [4:0] OP_JEQ = 5'h14, OP_JNQ = 5'h15;

  typedef enum logic [1:0] {
    PH_FETCH = 2'b00,
    PH_E1    = 2'b01,
    PH_E2    = 2'b10,
    PH_HALT  = 2'b11
  } phase_e;

  localparam logic [1:0] M1_MEM = 2'b00, M1_IMM = 2'b01, M1_ALU = 2'b10, M1_STK = 2'b11;
  localparam logic [1:0] PCM_IMM = 2'b00, PCM_REG = 2'b01, PCM_STK = 2'b10;

  typedef struct packed {
    logic alu_r;     // register-register ALU op (incl. BBO)
    logic alu_i;     // ALU op with immediate
    logic alu_m;     // ALU op with memory operand (two-cycle)
    logic two_cycle; // write happens in E2
    logic carry_op;  // arithmetic/shift: updates carry in write cycle
    logic ldi;
    logic st;        // STA / STI
    logic psh;
    logic pop;
    logic stp;
    logic jmp;
    logic jeq;
    logic jnq;
    logic jmr;
  } op_class_t;

endpackage

// File: rtl/decode_seq_opdec.sv
// decode_seq_opdec: purely combinational opcode -> op-class decode.
//   opc : INSTR[15:11] from the IR
//   oc  : op-class one-hots; illegal opcodes decode to all-zero (NOP)
module decode_seq_opdec
  import decode_seq_pkg::*;
(
  input  logic [4:0] opc,
  output op_class_t  oc
);

  always_comb begin
    oc = '0;
    case (opc)
      OP_STP: oc.stp = 1'b1;
      OP_ADR, OP_SBR, OP_MLR, OP_XSL, OP_XSR: begin
        oc.alu_r    = 1'b1;
        oc.carry_op = 1'b1;
      end
      OP_BBO: oc.alu_r = 1'b1;
      OP_ADI, OP_SBI: begin
        oc.alu_i    = 1'b1;
        oc.carry_op = 1'b1;
      end
      OP_ADM, OP_SBM: begin
        oc.alu_m     = 1'b1;
        oc.two_cycle = 1'b1;
        oc.carry_op  = 1'b1;
      end
      OP_LDR, OP_LDA: oc.two_cycle = 1'b1;
      OP_PSH: oc.psh = 1'b1;
      OP_POP: oc.pop = 1'b1;
      OP_STI, OP_STA: oc.st = 1'b1;
      OP_LDI: oc.ldi = 1'b1;
      OP_JMR: oc.jmr = 1'b1;
      OP_JMP: oc.jmp = 1'b1;
      OP_JEQ: oc.jeq = 1'b1;
      OP_JNQ: oc.jnq = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_sequencer.sv
// decode_sequencer: fetch/execute sequencer with IR, sitting between
// instruction memory and the datapath.
//   Inputs : clk, rst_n (sync, active-low), instr, mem_ready (low = stall),
//            eq, jmr_cond, stack_full, stack_empty
//   Outputs: phase (00 FETCH/01 E1/10 E2/11 HALT), instr_rden, pc_cnten,
//            pc_sload, pcmux_sel, reg_wen (one-hot on rd), mux1_sel, out_sel,
//            data_wren, carry_en, push_en, pop_en, halted, fault
//   Option : DECODE_SEQ_STACK_TRAP_EN -- PSH on full / POP on empty sets a
//            sticky fault and halts instead of stalling / NOP-ing.
module decode_sequencer
  import decode_seq_pkg::*;
#(
  parameter  int RSEL_W = 2,
  parameter  int OPC_W  = 5,
  localparam int NREG   = 2**RSEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              mem_ready,
  input  logic              eq,
  input  logic              jmr_cond,
  input  logic              stack_full,
  input  logic              stack_empty,
  output logic [1:0]        phase,
  output logic              instr_rden,
  output logic              pc_cnten,
  output logic              pc_sload,
  output logic [1:0]        pcmux_sel,
  output logic [NREG-1:0]   reg_wen,
  output logic [1:0]        mux1_sel,
  output logic [RSEL_W-1:0] out_sel,
  output logic              data_wren,
  output logic              carry_en,
  output logic              push_en,
  output logic              pop_en,
  output logic              halted,
  output logic              fault
);

  phase_e      state_q, state_d;
  logic [15:0] ir_q;
  logic        ir_load;
  op_class_t   oc;
  logic [RSEL_W-1:0] rd;
  logic        reg_wr, psh_blk, pop_ok, pop_pc, go;
  logic        unused_ir;

  assign rd        = ir_q[10 -: RSEL_W];
  assign unused_ir = ^ir_q;  // not every IR bit feeds a control output

  decode_seq_opdec u_opdec (
    .opc (ir_q[15 -: OPC_W]),
    .oc  (oc)
  );

`ifdef DECODE_SEQ_STACK_TRAP_EN
  logic fault_q, trap_set;
  always_ff @(posedge clk) begin
    if (!rst_n)        fault_q <= 1'b0;
    else if (trap_set) fault_q <= 1'b1;
  end
  assign fault = rst_n & fault_q;
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PH_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load) ir_q <= instr;
    end
  end

  assign phase = rst_n ? state_q : PH_FETCH;

  always_comb begin
    state_d    = state_q;
    ir_load    = 1'b0;
    instr_rden = 1'b0;
    pc_cnten   = 1'b0;
    pc_sload   = 1'b0;
    pcmux_sel  = PCM_IMM;
    reg_wr     = 1'b0;
    mux1_sel   = M1_MEM;
    out_sel    = '0;
    data_wren  = 1'b0;
    carry_en   = 1'b0;
    push_en    = 1'b0;
    pop_en     = 1'b0;
    halted     = 1'b0;
`ifdef DECODE_SEQ_STACK_TRAP_EN
    trap_set   = 1'b0;
`endif
    psh_blk = oc.psh & stack_full;
    pop_ok  = oc.pop & ~stack_empty;
    pop_pc  = oc.pop & ir_q[0];
    // E1 advances only when memory is ready and no push is blocked; the two
    // stall sources are independent and both must clear.
    go      = mem_ready & ~psh_blk;

    case (state_q)
      PH_FETCH: begin
        instr_rden = 1'b1;
        if (mem_ready) begin
          pc_cnten = 1'b1;
          ir_load  = 1'b1;
          state_d  = PH_E1;
        end
      end
      PH_E1: begin
        // Selects follow the decoded op; only the enables are stall-gated.
        if (oc.st)       out_sel = rd;
        else if (oc.jmr) out_sel = ir_q[RSEL_W-1:0];
        if (oc.ldi)                     mux1_sel = M1_IMM;
        else if (oc.alu_r | oc.alu_i)   mux1_sel = M1_ALU;
        else if (oc.pop & ~ir_q[0])     mux1_sel = M1_STK;
        if (oc.jmr)      pcmux_sel = PCM_REG;
        else if (pop_pc) pcmux_sel = PCM_STK;
`ifdef DECODE_SEQ_STACK_TRAP_EN
        if (psh_blk | (oc.pop & stack_empty)) begin
          trap_set = 1'b1;
          state_d  = PH_HALT;
        end else
`endif
        if (go) begin
          reg_wr    = oc.alu_r | oc.alu_i | oc.ldi | (pop_ok & ~ir_q[0]);
          carry_en  = oc.carry_op & ~oc.two_cycle;
          data_wren = oc.st;
          push_en   = oc.psh;
          pop_en    = pop_ok;
          pc_sload  = oc.jmp | (oc.jeq & eq) | (oc.jnq & ~eq) |
                      (oc.jmr & jmr_cond) | (pop_ok & ir_q[0]);
          if (oc.stp)            state_d = PH_HALT;
          else if (oc.two_cycle) state_d = PH_E2;
          else                   state_d = PH_FETCH;
        end
      end
      PH_E2: begin
        if (oc.alu_m) mux1_sel = M1_ALU;
        if (mem_ready) begin
          reg_wr   = oc.two_cycle;
          carry_en = oc.carry_op;
          state_d  = PH_FETCH;
        end
      end
      PH_HALT: halted = 1'b1;
      default: ;
    endcase

    reg_wen = reg_wr ? (NREG'(1) << rd) : '0;

    // Reset is synchronous, so the state may not be FETCH yet while rst_n is
    // low; force every output quiet regardless.
    if (!rst_n) begin
      instr_rden = 1'b0;
      pc_cnten   = 1'b0;
      pc_sload   = 1'b0;
      pcmux_sel  = '0;
      reg_wen    = '0;
      mux1_sel   = '0;
      out_sel    = '0;
      data_wren  = 1'b0;
      carry_en   = 1'b0;
      push_en    = 1'b0;
      pop_en     = 1'b0;
      halted     = 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_sequencer.sv
// tb_decode_sequencer: table-driven directed bench for decode_sequencer.
// A second instance with RSEL_W=3 shares all inputs and is checked for the
// wider one-hot register enable.
module tb_decode_sequencer;

  typedef struct packed {
    logic [1:0] phase;
    logic       rden, cnt, sload;
    logic [1:0] pcm;
    logic [3:0] wen;
    logic [1:0] m1;
    logic [1:0] os;
    logic       dw, ce, pu, po, hlt, flt;
  } out_t;

  typedef struct {
    logic        rst;
    logic [15:0] instr;
    logic        mr, eq, jc, sf, se;
    out_t        ex;
    logic        chk3;
    logic [7:0]  wen3;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, mem_ready, eq, jmr_cond, stack_full, stack_empty;
  logic [15:0] instr;

  logic [1:0] phase, pcmux_sel, mux1_sel, out_sel;
  logic       instr_rden, pc_cnten, pc_sload, data_wren, carry_en, push_en, pop_en, halted, fault;
  logic [3:0] reg_wen;

  logic [1:0] u3_phase, u3_pcmux_sel, u3_mux1_sel;
  logic [2:0] u3_out_sel;
  logic       u3_instr_rden, u3_pc_cnten, u3_pc_sload, u3_data_wren, u3_carry_en;
  logic       u3_push_en, u3_pop_en, u3_halted, u3_fault;
  logic [7:0] u3_reg_wen;

  int errs = 0;
  int checks = 0;

  vec_t  vq[$];
  string nq[$];

  always #5 clk = ~clk;

  decode_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .eq(eq),
    .jmr_cond(jmr_cond), .stack_full(stack_full), .stack_empty(stack_empty),
    .phase(phase), .instr_rden(instr_rden), .pc_cnten(pc_cnten), .pc_sload(pc_sload),
    .pcmux_sel(pcmux_sel), .reg_wen(reg_wen), .mux1_sel(mux1_sel), .out_sel(out_sel),
    .data_wren(data_wren), .carry_en(carry_en), .push_en(push_en), .pop_en(pop_en),
    .halted(halted), .fault(fault)
  );

  decode_sequencer #(.RSEL_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .eq(eq),
    .jmr_cond(jmr_cond), .stack_full(stack_full), .stack_empty(stack_empty),
    .phase(u3_phase), .instr_rden(u3_instr_rden), .pc_cnten(u3_pc_cnten),
    .pc_sload(u3_pc_sload), .pcmux_sel(u3_pcmux_sel), .reg_wen(u3_reg_wen),
    .mux1_sel(u3_mux1_sel), .out_sel(u3_out_sel), .data_wren(u3_data_wren),
    .carry_en(u3_carry_en), .push_en(u3_push_en), .pop_en(u3_pop_en),
    .halted(u3_halted), .fault(u3_fault)
  );

  function automatic out_t o(input logic [1:0] ph, input logic rd, input logic cn,
                             input logic sl, input logic [1:0] pm, input logic [3:0] w,
                             input logic [1:0] m, input logic [1:0] os, input logic dw,
                             input logic ce, input logic pu, input logic po, input logic hl);
    out_t r;
    r.phase = ph; r.rden = rd; r.cnt = cn; r.sload = sl; r.pcm = pm; r.wen = w;
    r.m1 = m; r.os = os; r.dw = dw; r.ce = ce; r.pu = pu; r.po = po; r.hlt = hl;
    r.flt = 1'b0;
    return r;
  endfunction

  task automatic add(input string nm, input logic r, input logic [15:0] i, input logic mr,
                     input logic e, input logic jc, input logic sf, input logic se,
                     input out_t ex);
    vec_t v;
    v.rst = r; v.instr = i; v.mr = mr; v.eq = e; v.jc = jc; v.sf = sf; v.se = se;
    v.ex = ex; v.chk3 = 1'b0; v.wen3 = '0;
    vq.push_back(v);
    nq.push_back(nm);
  endtask

  function automatic out_t actual();
    out_t a;
    a.phase = phase; a.rden = instr_rden; a.cnt = pc_cnten; a.sload = pc_sload;
    a.pcm = pcmux_sel; a.wen = reg_wen; a.m1 = mux1_sel; a.os = out_sel;
    a.dw = data_wren; a.ce = carry_en; a.pu = push_en; a.po = pop_en;
    a.hlt = halted; a.flt = fault;
    return a;
  endfunction

  initial begin
    out_t Z, FX, ex;
    Z  = o(2'd0, 0,0,0, 2'd0, 4'h0, 2'd0, 2'd0, 0,0,0,0,0);
    FX = o(2'd0, 1,1,0, 2'd0, 4'h0, 2'd0, 2'd0, 0,0,0,0,0);

    //   name        rst instr    mr eq jc sf se  expected
    add("rst0",      0, 16'h0800, 1, 0, 0, 0, 0, Z);
    add("rst1",      0, 16'h0800, 1, 0, 0, 0, 0, Z);
    add("adr_f",     1, 16'h0800, 1, 0, 0, 0, 0, FX);
    add("adr_e1",    1, 16'h0800, 1, 0, 0, 0, 0, o(2'd1, 0,0,0, 2'd0, 4'b0001, 2'b10, 2'd0, 0,1,0,0,0));
    add("lda_f",     1, 16'h8C00, 1, 0, 0, 0, 0, FX);
    add("lda_e1",    1, 16'h8C00, 1, 0, 0, 0, 0, o(2'd1, 0,0,0, 2'd0, 4'h0, 2'd0, 2'd0, 0,0,0,0,0));
    add("lda_e2",    1, 16'h8C00, 1, 0, 0, 0, 0, o(2'd2, 0,0,0, 2'd0, 4'b0100, 2'd0, 2'd0, 0,0,0,0,0));
    add("jeq0_f",    1, 16'hA000, 1, 0, 0, 0, 0, FX);
    add("jeq0_e1",   1, 16'hA000, 1, 0, 0, 0, 0, o(2'd1, 0,0,0, 2'd0, 4'h0, 2'd0, 2'd0, 0,0,0,0,0));
    add("jeq1_f",    1, 16'hA000, 1, 1, 0, 0, 0, FX);
    add("jeq1_e1",   1, 16'hA000, 1, 1, 0, 0, 0, o(2'd1, 0,0,1, 2'd0, 4'h0, 2'd0, 2'd0, 0,0,0,0,0));
    add("jmr_f",     1, 16'h9003, 1, 0, 1, 0, 0, FX);
    add("jmr_e1",    1, 16'h9003, 1, 0, 1, 0, 0, o(2'd1, 0,0,1, 2'b01, 4'h0, 2'd0, 2'd3, 0,0,0,0,0));
    add("sta_fhold", 1, 16'h8200, 0, 0, 0, 0, 0, o(2'd0, 1,0,0, 2'd0, 4'h0, 2'd0, 2'd0, 0,0,0,0,0));
    add("sta_f",     1, 16'h8200, 1, 0, 0, 0, 0, FX);
    add("sta_e1hold",1, 16'h8200, 0, 0, 0, 0, 0, o(2'd1, 0,0,0, 2'd0, 4'h0, 2'd0, 2'd1, 0,0,0,0,0));
    add("sta_e1",    1, 16'h8200, 1, 0, 0, 0, 0, o(2'd1, 0,0,0, 2'd0, 4'h0, 2'd0, 2'd1, 1,0,0,0,0));
    add("adi_f",     1, 16'h1500, 1, 0, 0, 0, 0, FX);
    add("adi_e1",    1, 16'h1500, 1, 0, 0, 0, 0, o(2'd1, 0,0,0, 2'd0, 4'b0100, 2'b10, 2'd0, 0,1,0,0,0));
    vq[$].chk3 = 1'b1;
    vq[$].wen3 = 8'b0010_0000;
    add("ill_f",     1, 16'hB000, 1, 0, 0, 0, 0, FX);
    add("ill_e1",    1, 16'hB000, 1, 0, 0, 0, 0, o(2'd1, 0,0,0, 2'd0, 4'h0, 2'd0, 2'd0, 0,0,0,0,0));
`ifndef DECODE_SEQ_STACK_TRAP_EN
    add("pope_f",    1, 16'h6200, 1, 0, 0, 0, 1, FX);
    add("pope_e1",   1, 16'h6200, 1, 0, 0, 0, 1, o(2'd1, 0,0,0, 2'd0, 4'h0, 2'b11, 2'd0, 0,0,0,0,0));
    add("pop_f",     1, 16'h6200, 1, 0, 0, 0, 0, FX);
    add("pop_e1",    1, 16'h6200, 1, 0, 0, 0, 0, o(2'd1, 0,0,0, 2'd0, 4'b0010, 2'b11, 2'd0, 0,0,0,1,0));
    add("poppc_f",   1, 16'h6001, 1, 0, 0, 0, 0, FX);
    add("poppc_e1",  1, 16'h6001, 1, 0, 0, 0, 0, o(2'd1, 0,0,1, 2'b10, 4'h0, 2'd0, 2'd0, 0,0,0,1,0));
    add("psh_f",     1, 16'h5800, 1, 0, 0, 1, 0, FX);
    add("psh_s1",    1, 16'h5800, 1, 0, 0, 1, 0, o(2'd1, 0,0,0, 2'd0, 4'h0, 2'd0, 2'd0, 0,0,0,0,0));
    add("psh_s2",    1, 16'h5800, 0, 0, 0, 1, 0, o(2'd1, 0,0,0, 2'd0, 4'h0, 2'd0, 2'd0, 0,0,0,0,0));
    add("psh_s3",    1, 16'h5800, 1, 0, 0, 1, 0, o(2'd1, 0,0,0, 2'd0, 4'h0, 2'd0, 2'd0, 0,0,0,0,0));
    add("psh_mrlow", 1, 16'h5800, 0, 0, 0, 0, 0, o(2'd1, 0,0,0, 2'd0, 4'h0, 2'd0, 2'd0, 0,0,0,0,0));
    add("psh_go",    1, 16'h5800, 1, 0, 0, 0, 0, o(2'd1, 0,0,0, 2'd0, 4'h0, 2'd0, 2'd0, 0,0,1,0,0));
`else
    add("psh_f",     1, 16'h5800, 1, 0, 0, 1, 0, FX);
    add("psh_trap",  1, 16'h5800, 1, 0, 0, 1, 0, o(2'd1, 0,0,0, 2'd0, 4'h0, 2'd0, 2'd0, 0,0,0,0,0));
    ex = o(2'd3, 0,0,0, 2'd0, 4'h0, 2'd0, 2'd0, 0,0,0,0,1);
    ex.flt = 1'b1;
    add("psh_halt",  1, 16'h5800, 1, 0, 0, 0, 0, ex);
    add("psh_halt2", 1, 16'h5800, 1, 0, 0, 0, 0, ex);
    add("psh_rst",   0, 16'h5800, 1, 0, 0, 0, 0, Z);
`endif
    add("lda2_f",    1, 16'h8C00, 1, 0, 0, 0, 0, FX);
    add("lda2_e1",   1, 16'h8C00, 1, 0, 0, 0, 0, o(2'd1, 0,0,0, 2'd0, 4'h0, 2'd0, 2'd0, 0,0,0,0,0));
    add("lda2_e2rst",0, 16'h8C00, 1, 0, 0, 0, 0, Z);
    add("post_rst",  1, 16'h0000, 1, 0, 0, 0, 0, FX);
    add("stp_e1",    1, 16'h0000, 1, 0, 0, 0, 0, o(2'd1, 0,0,0, 2'd0, 4'h0, 2'd0, 2'd0, 0,0,0,0,0));
    add("halt0",     1, 16'h0800, 1, 0, 0, 0, 0, o(2'd3, 0,0,0, 2'd0, 4'h0, 2'd0, 2'd0, 0,0,0,0,1));
    add("halt1",     1, 16'h0800, 0, 1, 1, 1, 1, o(2'd3, 0,0,0, 2'd0, 4'h0, 2'd0, 2'd0, 0,0,0,0,1));
    add("halt_rst",  0, 16'h0800, 1, 0, 0, 0, 0, Z);
    add("after_rst", 1, 16'h0000, 1, 0, 0, 0, 0, FX);

    for (int i = 0; i < vq.size(); i++) begin
      out_t a;
      rst_n = vq[i].rst; instr = vq[i].instr; mem_ready = vq[i].mr; eq = vq[i].eq;
      jmr_cond = vq[i].jc; stack_full = vq[i].sf; stack_empty = vq[i].se;
      @(negedge clk);
      a = actual();
      checks++;
      if (a !== vq[i].ex) begin
        errs++;
        $display("FAIL %s: got %h expected %h", nq[i], a, vq[i].ex);
      end
      if (vq[i].chk3) begin
        checks++;
        if (u3_reg_wen !== vq[i].wen3) begin
          errs++;
          $display("FAIL %s_rsel3: reg_wen got %b expected %b", nq[i], u3_reg_wen, vq[i].wen3);
        end
      end
      @(posedge clk); #1;
    end

    // Hand sequence: STP latched in the last fetch; HALT must persist under
    // arbitrary inputs until a reset edge.
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      mem_ready = 1'($urandom); eq = 1'($urandom); jmr_cond = 1'($urandom);
      stack_full = 1'($urandom); stack_empty = 1'($urandom); instr = 16'($urandom);
      @(negedge clk);
      checks++;
      if (!(phase === 2'b11 && halted === 1'b1 && instr_rden === 1'b0 && reg_wen === 4'h0 &&
            pc_sload === 1'b0 && push_en === 1'b0 && pop_en === 1'b0 && fault === 1'b0)) begin
        errs++;
        $display("FAIL halt_hold%0d: phase=%b halted=%b rden=%b wen=%b fault=%b expected phase=11 halted=1 rest 0",
                 k, phase, halted, instr_rden, reg_wen, fault);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (phase !== 2'b00 || halted !== 1'b0 || instr_rden !== 1'b1 || pc_cnten !== 1'b0) begin
      errs++;
      $display("FAIL halt_exit: phase=%b halted=%b rden=%b cnt=%b expected 00 0 1 0",
               phase, halted, instr_rden, pc_cnten);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/decode_sequencer.md
Name: decode_sequencer

Overview:
- Parametrised successor to the pipelined instruction decoder. Owns the fetch/execute phase state machine internally and latches the instruction into an IR.
- Generalises register count, adds memory-ready stalls, stack-full back-pressure and a halted state.
- Sits between instruction memory and the datapath (register file, ALU muxes, PC, stack).

Parameters:
- RSEL_W, 2, register-select width; NREG = 2**RSEL_W (legal values 2 or 3).
- OPC_W, 5, opcode width at INSTR[15 -: OPC_W]; fixed at 5 for this ISA.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- instr  in  16  instruction-memory read data
- mem_ready  in  1  instruction/data memory ready; low = stall
- eq  in  1  ALU equal flag
- jmr_cond  in  1  JMR condition
- stack_full  in  1  stack full
- stack_empty  in  1  stack empty
- phase  out  2  00 FETCH, 01 E1, 10 E2, 11 HALT
- instr_rden  out  1  instruction read
- pc_cnten  out  1  PC increment
- pc_sload  out  1  PC load
- pcmux_sel  out  2  00 immediate, 01 register (JMR), 10 stack (POP→PC)
- reg_wen  out  NREG  one-hot register write enable
- mux1_sel  out  2  00 mem, 01 imm, 10 ALU, 11 stack
- out_sel  out  RSEL_W  register driven onto store/jump bus
- data_wren  out  1  data write
- carry_en  out  1  carry flag update
- push_en  out  1  stack push
- pop_en  out  1  stack pop
- halted  out  1  in HALT
- fault  out  1  sticky stack fault (feature only; else tied 0)

Behaviour:
- Opcode decode (hex of INSTR[15:11]):
  - 00 STP, 01 ADR, 02 ADI, 03 ADM, 04 SBR, 05 SBI, 06 SBM, 07 MLR
  - 08 XSL, 09 XSR, 0A BBO, 0B PSH, 0C POP, 0D LDR, 0E STI, 0F LDI
  - 10 STA, 11 LDA, 12 JMR, 13 JMP, 14 JEQ, 15 JNQ
  - 16–1F illegal: execute as NOP, one E1 cycle.
- Fields: rd = INSTR[10 -: RSEL_W]; rs = INSTR[10-RSEL_W -: RSEL_W]. POP uses INSTR[0]=1 for destination PC, else destination rd.
- Reset:
  - State ← FETCH, IR ← 0, fault ← 0.
  - While rst_n = 0 every output is 0, including phase = 00.
- FETCH:
  - instr_rden = 1.
  - If mem_ready: IR ← instr, pc_cnten = 1, next state E1.
  - Else: hold, pc_cnten = 0.
- E1:
  - Two-cycle ops (ADM, SBM, LDR, LDA) go to E2.
  - STP goes to HALT.
  - All others go to FETCH.
  - mem_ready low holds E1; all write/stack/PC enables are forced 0 during the held cycle.
- E2: completes the two-cycle op, then FETCH. Honours mem_ready the same way as E1.
- HALT: all enables 0, halted = 1. Left only by reset.
- Register writes, one-hot on rd:
  - E1: ADR, SBR, MLR, XSL, XSR, BBO, ADI, SBI, LDI, POP with INSTR[0]=0.
  - E2: ADM, SBM, LDR, LDA.
- mux1_sel:
  - 01 for LDI.
  - 10 for ALU ops (E1) or ADM/SBM (E2).
  - 11 for POP to register.
  - Otherwise 00.
- carry_en: arithmetic/shift ops in their write cycle; BBO excluded.
- data_wren: STA or STI in E1.
- out_sel:
  - STA/STI: rd.
  - JMR: INSTR[RSEL_W-1:0].
  - Otherwise 0.
- pc_sload, in E1 only, when any of:
  - JMP;
  - JEQ & eq;
  - JNQ & ~eq;
  - JMR & jmr_cond (pcmux_sel = 01);
  - POP with INSTR[0]=1 & ~stack_empty (pcmux_sel = 10).
  A taken jump and the fetch increment never coincide, because the jump is in E1.
- PSH with stack_full: stall in E1, push_en = 0, until stack_full drops. Then push_en = 1 for exactly one cycle.
- POP with stack_empty: pop_en = 0, no register or PC write, proceed to FETCH (NOP).
- Simultaneous stack_full and mem_ready low: the stall holds. Each stall condition is independent; the earliest release wins nothing until both clear.
- reg_wen is one-hot or zero at all times.

Optional Feature:
- Macro: DECODE_SEQ_STACK_TRAP_EN.
- Enabled: PSH with stack_full, or POP with stack_empty, sets fault (sticky until reset), suppresses the operation and goes to HALT next cycle.
- Disabled: stall/NOP behaviour as above; fault tied 0.

Decomposition:
- Package decode_seq_pkg holds:
  - opcode localparams;
  - phase encoding;
  - mux1_sel and pcmux_sel codes.
- One sub-module, decode_seq_opdec: purely combinational IR → op-class one-hots (alu_r, alu_i, alu_m, two_cycle, jump kinds). The FSM and enables stay in the top.

Test Plan:
- Reset then instr=0x0800 (ADR rd=0) with mem_ready=1 → phases FETCH, E1, FETCH; reg_wen=0001 and mux1_sel=10 in E1; carry_en per rule.
- LDA rd=2 (0x8C00 with RSEL_W=2) → FETCH, E1, E2; reg_wen=0100 only in E2; pc_cnten=1 only in FETCH.
- JEQ with eq=0 then eq=1 → pc_sload 0 then 1 in E1, pcmux_sel=00; JMR with jmr_cond=1, INSTR[1:0]=3 → out_sel=3, pcmux_sel=01.
- PSH with stack_full=1 for 3 cycles → E1 held 3 cycles, push_en=0; push_en=1 for one cycle after release. With DECODE_SEQ_STACK_TRAP_EN: fault=1, then HALT.
- mem_ready=0 in FETCH and in E1 → state held, no enables asserted; STP → HALT, halted=1 until rst_n=0 at a clock edge.
- rst_n low during E2 → next edge FETCH, all outputs 0 while low; RSEL_W=3 build: ADI rd=5 → reg_wen=0010_0000.
